// File: rtl/iq_integrate_dump.sv
// XOR detection, windowed integrate-and-dump of I/Q detections with hard bit decision.
// Define IQ_SAT_EN for saturating accumulators; the default build wraps modulo 2^SUM_W.
module iq_integrate_dump #(
    parameter int SUM_W   = 5,
    parameter int WIN_LEN = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sync,
    input  logic             i_wf,
    input  logic             q_wf,
    input  logic             samp,
    output logic [SUM_W-1:0] isum,
    output logic [SUM_W-1:0] qsum,
    output logic             sum_valid,
    output logic             bit_out,
    output logic             tie,
    output logic             ovf,
    output logic [CNT_W-1:0] win_pos
);

    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(WIN_LEN - 1);

    logic             idect, qdect;
    logic [SUM_W:0]   i_ext, q_ext;
    logic [SUM_W-1:0] i_next, q_next;
    logic             i_ovf, q_ovf;

    logic [SUM_W-1:0] iacc_q, iacc_d, qacc_q, qacc_d;
    logic [CNT_W-1:0] win_pos_q, win_pos_d;
    logic             ovf_acc_q, ovf_acc_d;
    logic [SUM_W-1:0] isum_q, isum_d, qsum_q, qsum_d;
    logic             sum_valid_q, sum_valid_d;
    logic             bit_out_q, bit_out_d;
    logic             tie_q, tie_d;
    logic             ovf_q, ovf_d;

    assign idect = samp ^ i_wf;
    assign qdect = samp ^ q_wf;

    // The extra top bit of each sum is the carry-out used as the overflow flag.
    always_comb begin
        i_ext = {1'b0, iacc_q} + {{SUM_W{1'b0}}, idect};
        q_ext = {1'b0, qacc_q} + {{SUM_W{1'b0}}, qdect};
        i_ovf = i_ext[SUM_W];
        q_ovf = q_ext[SUM_W];
`ifdef IQ_SAT_EN
        i_next = i_ovf ? {SUM_W{1'b1}} : i_ext[SUM_W-1:0];
        q_next = q_ovf ? {SUM_W{1'b1}} : q_ext[SUM_W-1:0];
`else
        i_next = i_ext[SUM_W-1:0];
        q_next = q_ext[SUM_W-1:0];
`endif
    end

    always_comb begin
        iacc_d      = iacc_q;
        qacc_d      = qacc_q;
        win_pos_d   = win_pos_q;
        ovf_acc_d   = ovf_acc_q;
        isum_d      = isum_q;
        qsum_d      = qsum_q;
        sum_valid_d = 1'b0;
        bit_out_d   = bit_out_q;
        tie_d       = tie_q;
        ovf_d       = ovf_q;
        if (enable) begin
            if (sync) begin
                iacc_d    = '0;
                qacc_d    = '0;
                win_pos_d = '0;
                ovf_acc_d = 1'b0;
            end else if (win_pos_q == LAST_POS) begin
                isum_d      = i_next;
                qsum_d      = q_next;
                ovf_d       = ovf_acc_q | i_ovf | q_ovf;
                sum_valid_d = 1'b1;
                // On a tie the previous decision is kept.
                if (i_next > q_next) begin
                    bit_out_d = 1'b1;
                    tie_d     = 1'b0;
                end else if (i_next < q_next) begin
                    bit_out_d = 1'b0;
                    tie_d     = 1'b0;
                end else begin
                    tie_d     = 1'b1;
                end
                iacc_d    = '0;
                qacc_d    = '0;
                win_pos_d = '0;
                ovf_acc_d = 1'b0;
            end else begin
                iacc_d    = i_next;
                qacc_d    = q_next;
                ovf_acc_d = ovf_acc_q | i_ovf | q_ovf;
                win_pos_d = win_pos_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            iacc_q      <= '0;
            qacc_q      <= '0;
            win_pos_q   <= '0;
            ovf_acc_q   <= 1'b0;
            isum_q      <= '0;
            qsum_q      <= '0;
            sum_valid_q <= 1'b0;
            bit_out_q   <= 1'b0;
            tie_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            iacc_q      <= iacc_d;
            qacc_q      <= qacc_d;
            win_pos_q   <= win_pos_d;
            ovf_acc_q   <= ovf_acc_d;
            isum_q      <= isum_d;
            qsum_q      <= qsum_d;
            sum_valid_q <= sum_valid_d;
            bit_out_q   <= bit_out_d;
            tie_q       <= tie_d;
            ovf_q       <= ovf_d;
        end
    end

    assign isum      = isum_q;
    assign qsum      = qsum_q;
    assign sum_valid = sum_valid_q;
    assign bit_out   = bit_out_q;
    assign tie       = tie_q;
    assign ovf       = ovf_q;
    assign win_pos   = win_pos_q;

endmodule

// File: tb/tb_iq_integrate_dump.sv
// Bench for iq_integrate_dump: window vector table with dump scoreboard, hand sequences,
// and a small SUM_W=3 / WIN_LEN=10 instance for the overflow cases.
module tb_iq_integrate_dump;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable, sync, i_wf, q_wf, samp;
    logic [4:0]  isum, qsum;
    logic        sum_valid, bit_out, tie, ovf;
    logic [15:0] win_pos;

    logic        enable2, sync2, i_wf2, q_wf2, samp2;
    logic [2:0]  isum2, qsum2;
    logic        sum_valid2, bit_out2, tie2, ovf2;
    logic [3:0]  win_pos2;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

`ifdef IQ_SAT_EN
    localparam int EXP_OVF_SUM = 7;
`else
    localparam int EXP_OVF_SUM = 2;
`endif

    typedef struct {
        logic [15:0] ipat;
        logic [15:0] qpat;
        int          ei;
        int          eq;
        logic        eb;
        logic        et;
    } vec_t;

    typedef struct {
        int   edge_n;
        int   isum;
        int   qsum;
        logic bit_o;
        logic tie;
        logic ovf;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];

    iq_integrate_dump dut (
        .clk(clk), .reset(reset), .enable(enable), .sync(sync),
        .i_wf(i_wf), .q_wf(q_wf), .samp(samp),
        .isum(isum), .qsum(qsum), .sum_valid(sum_valid), .bit_out(bit_out),
        .tie(tie), .ovf(ovf), .win_pos(win_pos)
    );

    iq_integrate_dump #(.SUM_W(3), .WIN_LEN(10), .CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .enable(enable2), .sync(sync2),
        .i_wf(i_wf2), .q_wf(q_wf2), .samp(samp2),
        .isum(isum2), .qsum(qsum2), .sum_valid(sum_valid2), .bit_out(bit_out2),
        .tie(tie2), .ovf(ovf2), .win_pos(win_pos2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Any sum_valid must match the oldest pending window, one edge after its last sample.
    always @(negedge clk) begin
        if (sum_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_sum_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("dump_edge", cyc, e.edge_n);
                check("isum", int'(isum), e.isum);
                check("qsum", int'(qsum), e.qsum);
                check("bit_out", int'(bit_out), int'(e.bit_o));
                check("tie", int'(tie), int'(e.tie));
                check("ovf", int'(ovf), int'(e.ovf));
            end
        end
    end

    task automatic drive(input logic en, input logic sy, input logic id, input logic qd);
        logic s;
        s      = 1'($urandom_range(0, 1));
        samp   = s;
        i_wf   = s ^ id;
        q_wf   = s ^ qd;
        enable = en;
        sync   = sy;
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input logic en, input logic id, input logic qd);
        logic s;
        s       = 1'($urandom_range(0, 1));
        samp2   = s;
        i_wf2   = s ^ id;
        q_wf2   = s ^ qd;
        enable2 = en;
        sync2   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int ei, input int eq, input logic eb, input logic et);
        exp_t e;
        e.edge_n = cyc + 1;
        e.isum   = ei;
        e.qsum   = eq;
        e.bit_o  = eb;
        e.tie    = et;
        e.ovf    = 1'b0;
        sb.push_back(e);
    endtask

    task automatic run_window(input logic [15:0] ip, input logic [15:0] qp,
                              input int ei, input int eq, input logic eb, input logic et);
        for (int k = 0; k < 16; k++) begin
            if (k == 15) push_exp(ei, eq, eb, et);
            drive(1'b1, 1'b0, ip[k], qp[k]);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_isum"}, int'(isum), 0);
        check({tag, "_qsum"}, int'(qsum), 0);
        check({tag, "_sum_valid"}, int'(sum_valid), 0);
        check({tag, "_bit_out"}, int'(bit_out), 0);
        check({tag, "_tie"}, int'(tie), 0);
        check({tag, "_ovf"}, int'(ovf), 0);
        check({tag, "_win_pos"}, int'(win_pos), 0);
    endtask

    initial begin
        vecs[0] = '{16'hFFFF, 16'h0000, 16, 0,  1'b1, 1'b0};
        vecs[1] = '{16'h0000, 16'hFFFF, 0,  16, 1'b0, 1'b0};
        vecs[2] = '{16'h00FF, 16'h0F0F, 8,  8,  1'b0, 1'b1};
        vecs[3] = '{16'h0007, 16'h0003, 3,  2,  1'b1, 1'b0};
        vecs[4] = '{16'h5555, 16'h5555, 8,  8,  1'b1, 1'b1};
        vecs[5] = '{16'h0001, 16'h8003, 1,  3,  1'b0, 1'b0};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 16, 16, 1'b0, 1'b1};
        vecs[7] = '{16'h0000, 16'h0000, 0,  0,  1'b0, 1'b1};

        reset = 1'b1;
        enable = 1'b0; sync = 1'b0; samp = 1'b0; i_wf = 1'b0; q_wf = 1'b0;
        enable2 = 1'b0; sync2 = 1'b0; samp2 = 1'b0; i_wf2 = 1'b0; q_wf2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        check("reset_small_isum", int'(isum2), 0);
        check("reset_small_win_pos", int'(win_pos2), 0);
        reset = 1'b0;

        // Back-to-back windows from the table.
        for (int v = 0; v < 8; v++)
            run_window(vecs[v].ipat, vecs[v].qpat, vecs[v].ei, vecs[v].eq, vecs[v].eb, vecs[v].et);

        // Enable gap of 5 cycles after sample 7 stretches the window.
        for (int k = 0; k < 16; k++) begin
            if (k == 7) begin
                for (int g = 0; g < 5; g++) begin
                    drive(1'b0, 1'b0, 1'b1, 1'b1);
                    check("gap_win_pos", int'(win_pos), 7);
                    check("gap_isum_hold", int'(isum), 0);
                end
            end
            if (k == 15) push_exp(16, 0, 1'b1, 1'b0);
            drive(1'b1, 1'b0, 1'b1, 1'b0);
        end

        // sync on the last window position: no dump, outputs retained.
        for (int k = 0; k < 15; k++) drive(1'b1, 1'b0, 1'b1, 1'b0);
        check("pre_sync_win_pos", int'(win_pos), 15);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        check("sync_win_pos", int'(win_pos), 0);
        check("sync_sum_valid", int'(sum_valid), 0);
        check("sync_isum_hold", int'(isum), 16);
        check("sync_qsum_hold", int'(qsum), 0);
        run_window(16'hFFFF, 16'hFFFF, 16, 16, 1'b1, 1'b1);

        // Reset mid-window discards the partial window.
        for (int k = 0; k < 8; k++) drive(1'b1, 1'b0, 1'b1, 1'b0);
        check("pre_reset_win_pos", int'(win_pos), 8);
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        check_all_zero("midreset");
        run_window(16'h0003, 16'h0001, 2, 1, 1'b1, 1'b0);

        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("scoreboard_drained", sb.size(), 0);

        // Small instance: 10 detections into a 3-bit accumulator.
        for (int k = 0; k < 10; k++) begin
            if (k == 9) check("small_pre_dump_win_pos", int'(win_pos2), 9);
            drive2(1'b1, 1'b1, 1'b0);
        end
        check("small_sum_valid", int'(sum_valid2), 1);
        check("small_isum", int'(isum2), EXP_OVF_SUM);
        check("small_qsum", int'(qsum2), 0);
        check("small_ovf", int'(ovf2), 1);
        check("small_bit_out", int'(bit_out2), 1);
        check("small_tie", int'(tie2), 0);
        for (int k = 0; k < 10; k++) drive2(1'b1, (k < 3) ? 1'b1 : 1'b0, 1'b0);
        check("small2_sum_valid", int'(sum_valid2), 1);
        check("small2_isum", int'(isum2), 3);
        check("small2_ovf", int'(ovf2), 0);
        drive2(1'b0, 1'b0, 1'b0);
        check("small_valid_drop", int'(sum_valid2), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
